// File: rtl/oled_multiring_renderer_pkg.sv
// Shared types, colours and ring-hit arithmetic for the multi-ring OLED renderer.
package oled_ring_pkg;

    typedef enum logic {
        LOCKED = 1'b0,
        ACTIVE = 1'b1
    } ring_state_e;

    typedef logic [7:0]  dia_t;     // ring diameter, px
    typedef logic [15:0] dist_t;    // 4*(dx^2+dy^2)
    typedef logic [15:0] rgb565_t;

    localparam rgb565_t C_BLACK  = 16'h0000;
    localparam rgb565_t C_WHITE  = 16'hFFFF;
    localparam rgb565_t C_BORDER = 16'hA800;

    // Index 0 is the rightmost entry: green, blue, red, yellow, cyan, magenta, orange, grey.
    localparam logic [7:0][15:0] RING_PALETTE = {
        16'h8410, 16'hFD20, 16'hF81F, 16'h07FF,
        16'hFFE0, 16'hF800, 16'h001F, 16'h0540
    };

    // dist4 is 4*r^2, so comparing against diameter squares avoids any halving or divide.
    function automatic logic ring_hit(input dist_t dist4, input dia_t outer_d, input dia_t ring_w);
        dia_t  inner;
        dist_t lo;
        dist_t hi;
        inner = (outer_d > ring_w) ? dia_t'(outer_d - ring_w) : '0;
        lo    = {8'b0, inner} * {8'b0, inner};
        hi    = {8'b0, outer_d} * {8'b0, outer_d};
        return (dist4 >= lo) && (dist4 <= hi);
    endfunction

endpackage

// File: rtl/oled_multiring_renderer_if.sv
// Board/driver-facing bundle of the renderer. pulse_sw exists only with ORING_PULSE_EN.
interface oled_multiring_renderer_if;
    logic [3:0]  btn;
    logic [15:0] sw;
    logic [12:0] pixel_index;
    logic [15:0] oled_data;
    logic [2:0]  sel_ring;
`ifdef ORING_PULSE_EN
    logic        pulse_sw;
    modport master (output btn, sw, pixel_index, pulse_sw, input oled_data, sel_ring);
    modport slave  (input btn, sw, pixel_index, pulse_sw, output oled_data, sel_ring);
`else
    modport master (output btn, sw, pixel_index, input oled_data, sel_ring);
    modport slave  (input btn, sw, pixel_index, output oled_data, sel_ring);
`endif
endinterface

// File: rtl/oled_multiring_renderer_btn_debounce.sv
// One-bit button conditioner: 2-FF synchroniser, stable-level counter, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 6250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[0], btn_in};
    end

    // Accept a new level only after it differs from the stable one for DEBOUNCE_CYC cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else if (sync[1] == stable) begin
            cnt  <= '0;
            rise <= 1'b0;
        end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
            stable <= sync[1];
            cnt    <= '0;
            rise   <= sync[1];
        end else begin
            cnt  <= cnt + CW'(1);
            rise <= 1'b0;
        end
    end
endmodule

// File: rtl/oled_multiring_renderer.sv
// Border plus NUM_RINGS concentric rings on the OLED pixel stream, button-driven ring
// select/toggle/resize, switch lock. Optional ORING_PULSE_EN adds a ping-pong pulse mode.
module oled_multiring_renderer
    import oled_ring_pkg::*;
#(
    parameter int          W              = 96,
    parameter int          H              = 64,
    parameter int          NUM_RINGS      = 3,
    parameter int          DEF_D          = 20,
    parameter int          RING_GAP       = 10,
    parameter int          RING_W         = 5,
    parameter int          STEP           = 5,
    parameter int          MIN_D          = 10,
    parameter int          MAX_D          = 60,
    parameter int          BORDER_INSET   = 3,
    parameter int          BORDER_W       = 3,
    parameter int          DEBOUNCE_CYC   = 6250,
    parameter logic [15:0] UNLOCK_PATTERN = 16'h0000
`ifdef ORING_PULSE_EN
    , parameter int        PULSE_PERIOD   = 625000
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    oled_multiring_renderer_if.slave  bus
);
    localparam dia_t        STEP_D    = dia_t'(STEP);
    localparam dia_t        MIN_DD    = dia_t'(MIN_D);
    localparam dia_t        MAX_DD    = dia_t'(MAX_D);
    localparam dia_t        RW_D      = dia_t'(RING_W);
    localparam logic [12:0] W13       = 13'(W);
    localparam logic [12:0] CX        = 13'(W / 2);
    localparam logic [12:0] CY        = 13'(H / 2);
    localparam logic [12:0] NPIX      = 13'(W * H);
    localparam logic [12:0] B_LO      = 13'(BORDER_INSET);
    localparam logic [12:0] BX_HI     = 13'(W - 1 - BORDER_INSET);
    localparam logic [12:0] BY_HI     = 13'(H - 1 - BORDER_INSET);
    localparam logic [12:0] BI_LO     = 13'(BORDER_INSET + BORDER_W);
    localparam logic [12:0] BIX_HI    = 13'(W - 1 - BORDER_INSET - BORDER_W);
    localparam logic [12:0] BIY_HI    = 13'(H - 1 - BORDER_INSET - BORDER_W);
    localparam logic [2:0]  LAST_RING = 3'(NUM_RINGS - 1);

    function automatic dia_t reset_d(input int i);
        return dia_t'(DEF_D + i * RING_GAP);
    endfunction

    // 9-bit sums so a large STEP cannot wrap past the bound checks.
    function automatic logic can_grow(input dia_t d);
        return ({1'b0, d} + {1'b0, STEP_D}) <= {1'b0, MAX_DD};
    endfunction

    function automatic logic can_shrink(input dia_t d);
        return {1'b0, d} >= ({1'b0, MIN_DD} + {1'b0, STEP_D});
    endfunction

    logic [3:0] rise;

    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_in (bus.btn[g]),
            .rise   (rise[g])
        );
    end

    ring_state_e          state;
    logic [2:0]           sel_ring;
    logic [NUM_RINGS-1:0] ring_en;
    dia_t                 outer_d [NUM_RINGS];
    logic                 unlocked;
    logic                 pulsing;
    logic                 do_grow;
    logic                 do_shrink;

    assign unlocked = (bus.sw == UNLOCK_PATTERN);

`ifdef ORING_PULSE_EN
    localparam int PCW = $clog2(PULSE_PERIOD + 1);
    logic [PCW-1:0]       pulse_cnt;
    logic [NUM_RINGS-1:0] grow_dir;
    logic                 fire;
    assign pulsing = bus.pulse_sw;
    assign fire    = pulsing && (state == ACTIVE) && (pulse_cnt == PCW'(PULSE_PERIOD - 1));
`else
    assign pulsing = 1'b0;
`endif

    // Opposing resize edges cancel; buttons cannot resize while pulsing.
    assign do_grow   = rise[1] && !rise[2] && !pulsing;
    assign do_shrink = rise[2] && !rise[1] && !pulsing;

    // Lock/active FSM with ring configuration; sw mismatch wipes config on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOCKED;
            sel_ring <= '0;
            ring_en  <= '0;
            for (int i = 0; i < NUM_RINGS; i++) outer_d[i] <= reset_d(i);
`ifdef ORING_PULSE_EN
            grow_dir  <= '1;
            pulse_cnt <= '0;
`endif
        end else if (!unlocked) begin
            state    <= LOCKED;
            sel_ring <= '0;
            ring_en  <= '0;
            for (int i = 0; i < NUM_RINGS; i++) outer_d[i] <= reset_d(i);
`ifdef ORING_PULSE_EN
            grow_dir  <= '1;
            pulse_cnt <= '0;
`endif
        end else begin
            state <= ACTIVE;
`ifdef ORING_PULSE_EN
            pulse_cnt <= (!pulsing || state != ACTIVE || fire) ? '0 : pulse_cnt + PCW'(1);
`endif
            if (state == ACTIVE) begin
                // Actions hit the ring selected before any simultaneous select edge.
                for (int i = 0; i < NUM_RINGS; i++) begin
                    if (sel_ring == 3'(i)) begin
                        if (rise[0]) ring_en[i] <= !ring_en[i];
                        if (do_grow && can_grow(outer_d[i]))     outer_d[i] <= outer_d[i] + STEP_D;
                        if (do_shrink && can_shrink(outer_d[i])) outer_d[i] <= outer_d[i] - STEP_D;
                    end
                end
`ifdef ORING_PULSE_EN
                // Ping-pong every enabled ring between MIN_D and MAX_D.
                if (fire) begin
                    for (int i = 0; i < NUM_RINGS; i++) begin
                        if (ring_en[i]) begin
                            if (grow_dir[i]) begin
                                if (can_grow(outer_d[i])) outer_d[i] <= outer_d[i] + STEP_D;
                                else begin
                                    grow_dir[i] <= 1'b0;
                                    if (can_shrink(outer_d[i])) outer_d[i] <= outer_d[i] - STEP_D;
                                end
                            end else begin
                                if (can_shrink(outer_d[i])) outer_d[i] <= outer_d[i] - STEP_D;
                                else begin
                                    grow_dir[i] <= 1'b1;
                                    if (can_grow(outer_d[i])) outer_d[i] <= outer_d[i] + STEP_D;
                                end
                            end
                        end
                    end
                end
`endif
                if (rise[3]) sel_ring <= (sel_ring == LAST_RING) ? 3'd0 : sel_ring + 3'd1;
            end
        end
    end

    logic [12:0]          x_pos, y_pos, ax, ay;
    logic [25:0]          sq;
    dist_t                dist4;
    logic                 border_on;
    logic [NUM_RINGS-1:0] ring_on;
    rgb565_t              colour;
    rgb565_t              oled_q;

    assign x_pos = bus.pixel_index % W13;
    assign y_pos = bus.pixel_index / W13;
    assign ax    = (x_pos >= CX) ? x_pos - CX : CX - x_pos;
    assign ay    = (y_pos >= CY) ? y_pos - CY : CY - y_pos;
    assign sq    = {13'b0, ax} * {13'b0, ax} + {13'b0, ay} * {13'b0, ay};
    assign dist4 = dist_t'(sq << 2);

    assign border_on = (x_pos >= B_LO) && (x_pos <= BX_HI) && (y_pos >= B_LO) && (y_pos <= BY_HI) &&
                       ((x_pos < BI_LO) || (x_pos > BIX_HI) || (y_pos < BI_LO) || (y_pos > BIY_HI));

    for (genvar g = 0; g < NUM_RINGS; g++) begin : g_hit
        assign ring_on[g] = ring_en[g] && ring_hit(dist4, outer_d[g], RW_D);
    end

    // Colour priority: selected > higher index > lower index > border > black.
    always_comb begin
        colour = C_BLACK;
        if (border_on) colour = C_BORDER;
        for (int i = 0; i < NUM_RINGS; i++)
            if (ring_on[i]) colour = RING_PALETTE[3'(i)];
        for (int i = 0; i < NUM_RINGS; i++)
            if (ring_on[i] && sel_ring == 3'(i)) colour = C_WHITE;
        if (!unlocked || state != ACTIVE || bus.pixel_index >= NPIX) colour = C_BLACK;
    end

    // One-cycle registered pixel output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) oled_q <= C_BLACK;
        else        oled_q <= colour;
    end

    assign bus.oled_data = oled_q;
    assign bus.sel_ring  = sel_ring;
endmodule

// File: tb/tb_oled_multiring_renderer.sv
// Self-checking bench for oled_multiring_renderer against a geometric reference model.
module tb_oled_multiring_renderer;
    import oled_ring_pkg::*;

    localparam int W = 96, H = 64, NR = 3, DEF_D = 20, GAP = 10, RW = 5, STEP = 5;
    localparam int MIN_D = 10, MAX_D = 60, INS = 3, BW = 3, DB = 4;
    localparam logic [15:0] PAT = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;

    int   m_d [NR];
    bit   m_en [NR];
    int   m_sel;

    oled_multiring_renderer_if bus ();

    oled_multiring_renderer #(
        .W(W), .H(H), .NUM_RINGS(NR), .DEF_D(DEF_D), .RING_GAP(GAP), .RING_W(RW),
        .STEP(STEP), .MIN_D(MIN_D), .MAX_D(MAX_D), .BORDER_INSET(INS), .BORDER_W(BW),
        .DEBOUNCE_CYC(DB), .UNLOCK_PATTERN(PAT)
`ifdef ORING_PULSE_EN
        , .PULSE_PERIOD(4)
`endif
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

    function automatic int pidx(input int x, input int y);
        return y * W + x;
    endfunction

    function automatic bit in_ring(input int d4, input int d);
        return ((d - RW) * (d - RW) <= d4) && (d4 <= d * d);
    endfunction

    function automatic logic [15:0] exp_pix(input int idx);
        int x, y, dx, dy, d4;
        logic [15:0] c;
        if (idx >= W * H) return 16'h0000;
        x = idx % W; y = idx / W;
        dx = x - W / 2; dy = y - H / 2;
        d4 = 4 * (dx * dx + dy * dy);
        c = 16'h0000;
        if (x >= INS && x <= W - 1 - INS && y >= INS && y <= H - 1 - INS &&
            (x < INS + BW || x > W - 1 - INS - BW || y < INS + BW || y > H - 1 - INS - BW))
            c = 16'hA800;
        for (int i = 0; i < NR; i++)
            if (m_en[i] && in_ring(d4, m_d[i])) c = (i == 0) ? 16'h0540 : RING_PALETTE[3'(i)];
        if (m_en[m_sel] && in_ring(d4, m_d[m_sel])) c = 16'hFFFF;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_d[i] = DEF_D + i * GAP;
            m_en[i] = 1'b0;
        end
        m_sel = 0;
    endtask

    task automatic model_apply(input logic [3:0] m);
        if (m[0]) m_en[m_sel] = !m_en[m_sel];
        if (m[1] && !m[2] && m_d[m_sel] + STEP <= MAX_D) m_d[m_sel] += STEP;
        if (m[2] && !m[1] && m_d[m_sel] - STEP >= MIN_D) m_d[m_sel] -= STEP;
        if (m[3]) m_sel = (m_sel + 1) % NR;
    endtask

    // Press and release a button mask long enough to pass the debouncer, then update the model.
    task automatic press(input logic [3:0] m);
        @(negedge clk) bus.btn = m;
        repeat (12) @(negedge clk);
        bus.btn = 4'b0000;
        repeat (12) @(negedge clk);
        model_apply(m);
    endtask

    task automatic sample_pix(input int idx, output logic [15:0] obs);
        @(negedge clk) bus.pixel_index = 13'(idx);
        @(posedge clk);
        #1 obs = bus.oled_data;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        bus.btn = 4'b0000; bus.sw = PAT; bus.pixel_index = 13'(pidx(58, 32));
`ifdef ORING_PULSE_EN
        bus.pulse_sw = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oled_data !== 16'h0000) begin
            failures++; $display("FAIL reset_oled got=%h exp=0000", bus.oled_data);
        end
        checks++;
        if (bus.sel_ring !== 3'd0) begin
            failures++; $display("FAIL reset_sel got=%0d exp=0", bus.sel_ring);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        sample_pix(pidx(3, 3), obs);
        checks++;
        if (obs !== 16'hA800) begin
            failures++; $display("FAIL t1_border got=%h exp=a800", obs);
        end
        sample_pix(pidx(48, 32), obs);
        checks++;
        if (obs !== 16'h0000) begin
            failures++; $display("FAIL t1_centre got=%h exp=0000", obs);
        end
    endtask

    task automatic test_toggle();
        logic [15:0] obs;
        press(4'b0001);
        sample_pix(pidx(58, 32), obs);
        checks++;
        if (obs !== 16'hFFFF) begin
            failures++; $display("FAIL t2_ring0_white got=%h exp=ffff", obs);
        end
    endtask

    task automatic test_resize();
        logic [15:0] obs;
        int probe;
        for (int k = 0; k < 9; k++) begin
            press(4'b0010);
            probe = pidx(W / 2 + (m_d[0] - 2) / 2, H / 2);
            sample_pix(probe, obs);
            checks++;
            if (obs !== exp_pix(probe)) begin
                failures++; $display("FAIL t3_grow k=%0d got=%h exp=%h", k, obs, exp_pix(probe));
            end
        end
        sample_pix(pidx(W / 2 + 29, H / 2), obs);
        checks++;
        if (obs !== 16'hFFFF) begin
            failures++; $display("FAIL t3_at_max got=%h exp=ffff", obs);
        end
        for (int k = 0; k < 12; k++) press(4'b0100);
        sample_pix(pidx(W / 2 + 4, H / 2), obs);
        checks++;
        if (obs !== 16'hFFFF) begin
            failures++; $display("FAIL t3_at_min got=%h exp=ffff", obs);
        end
        sample_pix(pidx(W / 2 + 6, H / 2), obs);
        checks++;
        if (obs !== exp_pix(pidx(W / 2 + 6, H / 2))) begin
            failures++; $display("FAIL t3_below_min got=%h exp=%h", obs, exp_pix(pidx(W / 2 + 6, H / 2)));
        end
    endtask

    task automatic test_select();
        logic [15:0] obs;
        logic [2:0] exp_sel [3] = '{3'd1, 3'd2, 3'd0};
        for (int k = 0; k < 3; k++) begin
            press(4'b1000);
            #1;
            checks++;
            if (bus.sel_ring !== exp_sel[k]) begin
                failures++; $display("FAIL t4_sel k=%0d got=%0d exp=%0d", k, bus.sel_ring, exp_sel[k]);
            end
        end
        press(4'b0110);
        for (int k = 0; k < 2; k++) begin
            sample_pix(pidx(W / 2 + 4 + 2 * k, H / 2), obs);
            checks++;
            if (obs !== exp_pix(pidx(W / 2 + 4 + 2 * k, H / 2))) begin
                failures++; $display("FAIL t4_both_resize k=%0d got=%h exp=%h", k, obs,
                                     exp_pix(pidx(W / 2 + 4 + 2 * k, H / 2)));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] obs;
        logic [3:0] m;
        int idx, i, r, x, y;
        for (int k = 0; k < 40; k++) begin
            m = 4'($urandom_range(1, 15));
            press(m);
            #1;
            checks++;
            if (bus.sel_ring !== 3'(m_sel)) begin
                failures++; $display("FAIL rnd_sel k=%0d mask=%b got=%0d exp=%0d", k, m, bus.sel_ring, m_sel);
            end
            i = $urandom_range(0, NR - 1);
            r = m_d[i] / 2 - $urandom_range(0, 3);
            x = ($urandom_range(0, 1) == 1) ? W / 2 + r : W / 2 - r;
            y = H / 2 + $urandom_range(0, 2) - 1;
            idx = pidx(x, y);
            sample_pix(idx, obs);
            checks++;
            if (obs !== exp_pix(idx)) begin
                failures++; $display("FAIL rnd_ring_pix k=%0d idx=%0d got=%h exp=%h", k, idx, obs, exp_pix(idx));
            end
            idx = $urandom_range(0, 8191);
            sample_pix(idx, obs);
            checks++;
            if (obs !== exp_pix(idx)) begin
                failures++; $display("FAIL rnd_any_pix k=%0d idx=%0d got=%h exp=%h", k, idx, obs, exp_pix(idx));
            end
        end
    endtask

    task automatic test_boundary();
        logic [15:0] obs;
        int idx [2] = '{W * H, 8191};
        for (int k = 0; k < 2; k++) begin
            sample_pix(idx[k], obs);
            checks++;
            if (obs !== 16'h0000) begin
                failures++; $display("FAIL out_of_range idx=%0d got=%h exp=0000", idx[k], obs);
            end
        end
    endtask

    task automatic test_lock();
        logic [15:0] obs;
        int probe;
        @(negedge clk);
        bus.pixel_index = 13'(pidx(3, 3));
        bus.sw = 16'($urandom_range(1, 65535));
        @(posedge clk);
        #1;
        checks++;
        if (bus.oled_data !== 16'h0000) begin
            failures++; $display("FAIL t5_lock_black got=%h exp=0000", bus.oled_data);
        end
        checks++;
        if (bus.sel_ring !== 3'd0) begin
            failures++; $display("FAIL t5_lock_sel got=%0d exp=0", bus.sel_ring);
        end
        // Button activity while locked must be discarded.
        @(negedge clk) bus.btn = 4'b1011;
        repeat (12) @(negedge clk);
        bus.btn = 4'b0000;
        repeat (12) @(negedge clk);
        bus.sw = PAT;
        repeat (3) @(negedge clk);
        model_reset();
        for (int i = 0; i < NR; i++) begin
            probe = pidx(W / 2 + (DEF_D + i * GAP - 2) / 2, H / 2);
            sample_pix(probe, obs);
            checks++;
            if (obs !== exp_pix(probe)) begin
                failures++; $display("FAIL t5_disabled ring=%0d got=%h exp=%h", i, obs, exp_pix(probe));
            end
        end
        press(4'b0001);
        sample_pix(pidx(58, 32), obs);
        checks++;
        if (obs !== 16'hFFFF) begin
            failures++; $display("FAIL t5_reset_diam got=%h exp=ffff", obs);
        end
        press(4'b1000);
        press(4'b0001);
        press(4'b1000);
        probe = pidx(W / 2 + 14, H / 2);
        sample_pix(probe, obs);
        checks++;
        if (obs !== exp_pix(probe)) begin
            failures++; $display("FAIL t5_ring1_palette got=%h exp=%h", obs, exp_pix(probe));
        end
    endtask

`ifdef ORING_PULSE_EN
    task automatic test_pulse();
        int d, dir, seen;
        @(negedge clk) bus.sw = 16'h1234;
        repeat (2) @(negedge clk);
        bus.sw = PAT;
        repeat (3) @(negedge clk);
        model_reset();
        press(4'b0001);
        for (int k = 0; k < 7; k++) press(4'b0010);
        d = m_d[0];
        dir = 1;
        bus.pulse_sw = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (dir == 1) begin
                if (d + STEP <= MAX_D) d += STEP; else begin dir = -1; d -= STEP; end
            end else begin
                if (d - STEP >= MIN_D) d -= STEP; else begin dir = 1; d += STEP; end
            end
            bus.pixel_index = 13'(pidx(W / 2 + (d - 2) / 2, H / 2));
            seen = 0;
            for (int c = 0; c < 16 && seen == 0; c++) begin
                @(posedge clk);
                #1 if (bus.oled_data === 16'hFFFF) seen = 1;
            end
            checks++;
            if (seen == 0) begin
                failures++; $display("FAIL t6_pulse k=%0d d=%0d got=%h exp=ffff", k, d, bus.oled_data);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.oled_data !== 16'h0000 || bus.sel_ring !== 3'd0) begin
            failures++; $display("FAIL t6_reset got=%h/%0d exp=0000/0", bus.oled_data, bus.sel_ring);
        end
        bus.pulse_sw = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_toggle();
        test_resize();
        test_select();
        test_random();
        test_boundary();
        test_lock();
`ifdef ORING_PULSE_EN
        test_pulse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
